// File: rtl/router_sync_n_if.sv
// rtl/router_sync_n_if.sv - FSM/FIFO-side signal bundle for the router synchroniser
interface router_sync_n_if #(
   parameter int NUM_CH = 3,
   parameter int ADDR_W = 2
);
   logic [ADDR_W-1:0] data_in;
   logic              detect_add;
   logic              write_enb_reg;
   logic [NUM_CH-1:0] read_enb;
   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] empty;
   logic              timeout_clr;
   logic [NUM_CH-1:0] vld_out;
   logic [NUM_CH-1:0] write_enb;
   logic [NUM_CH-1:0] soft_reset;
   logic              fifo_full;
   logic              addr_err;
   logic [NUM_CH-1:0] timeout_sts;

   modport master (
      output data_in, detect_add, write_enb_reg, read_enb, full, empty, timeout_clr,
      input  vld_out, write_enb, soft_reset, fifo_full, addr_err, timeout_sts
   );

   modport slave (
      input  data_in, detect_add, write_enb_reg, read_enb, full, empty, timeout_clr,
      output vld_out, write_enb, soft_reset, fifo_full, addr_err, timeout_sts
   );
endinterface

// File: rtl/router_sync_n.sv
// rtl/router_sync_n.sv - NUM_CH-port router synchroniser with per-channel read timeout
module router_sync_n #(
   parameter int NUM_CH  = 3,
   parameter int ADDR_W  = 2,
   parameter int TIMEOUT = 30,
   parameter int CNT_W   = 10
) (
   input logic            clock,
   input logic            reset,
   router_sync_n_if.slave sif
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [ADDR_W-1:0] addr_reg;
   logic              addr_err_q;
   logic [CNT_W-1:0]  cnt [NUM_CH];
   logic [NUM_CH-1:0] soft_reset_q;
   logic [NUM_CH-1:0] timeout_sts_q;
   logic [NUM_CH-1:0] sel;
   logic [NUM_CH-1:0] vld;
   logic [NUM_CH-1:0] expire;

   // sel is all-zero when the latched address is out of range
   always_comb begin
      sel    = '0;
      expire = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sel[i]    = (addr_reg == ADDR_W'(i));
         expire[i] = vld[i] & ~sif.read_enb[i] & (cnt[i] == CNT_LAST);
      end
   end

   assign vld             = ~sif.empty;
   assign sif.vld_out     = vld;
   assign sif.write_enb   = sel & {NUM_CH{sif.write_enb_reg & ~addr_err_q & ~reset}};
   assign sif.fifo_full   = (|(sif.full & sel)) & ~addr_err_q;
   assign sif.addr_err    = addr_err_q;
   assign sif.soft_reset  = soft_reset_q;
   assign sif.timeout_sts = timeout_sts_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         addr_reg   <= '0;
         addr_err_q <= 1'b0;
      end else if (sif.detect_add) begin
         addr_reg   <= sif.data_in;
         addr_err_q <= ({1'b0, sif.data_in} >= (ADDR_W + 1)'(NUM_CH));
      end
   end

   // Every channel counts on its own, independent of the addressed port
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
         soft_reset_q  <= '0;
         timeout_sts_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!vld[i] || sif.read_enb[i] || expire[i]) cnt[i] <= '0;
            else                                          cnt[i] <= cnt[i] + CNT_W'(1);
         end
         soft_reset_q  <= expire;
         timeout_sts_q <= (timeout_sts_q & ~{NUM_CH{sif.timeout_clr}}) | expire;
      end
   end
endmodule

// File: tb/tb_router_sync_n.sv
// tb/tb_router_sync_n.sv - directed scoreboard bench for router_sync_n
module tb_router_sync_n;
   logic clock;
   logic reset;

   router_sync_n_if #(.NUM_CH(3), .ADDR_W(2)) sif ();

   router_sync_n #(.NUM_CH(3), .ADDR_W(2), .TIMEOUT(30), .CNT_W(10)) dut (
      .clock (clock),
      .reset (reset),
      .sif   (sif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic expect_val(input string tag, input logic [15:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic check_obs(input logic [15:0] obs);
      exp_t e;
      e = sb.pop_front();
      tests++;
      assert (obs === e.val)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Advance edges until any masked soft_reset bit is seen, bounded at 40
   task automatic edges_to_pulse(input logic [2:0] mask, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (((sif.soft_reset & mask) == 3'b000) && (n < 40));
   endtask

   int n;

   initial begin
      reset             = 1'b1;
      sif.data_in       = 2'd3;
      sif.detect_add    = 1'b1;
      sif.write_enb_reg = 1'b1;
      sif.read_enb      = 3'b000;
      sif.full          = 3'b111;
      sif.empty         = 3'b010;
      sif.timeout_clr   = 1'b0;
      #1;
      expect_val("rst_wen_a", 16'h0); check_obs(16'(sif.write_enb));
      expect_val("rst_vld",   16'h5); check_obs(16'(sif.vld_out));
      step();
      sif.data_in = 2'd1; sif.empty = 3'b000; #1;
      expect_val("rst_wen_b", 16'h0); check_obs(16'(sif.write_enb));
      step();
      reset = 1'b0; sif.detect_add = 1'b0; sif.write_enb_reg = 1'b0;
      sif.empty = 3'b111; sif.full = 3'b000;
      #1;
      expect_val("rst_aerr", 16'h0); check_obs(16'(sif.addr_err));
      expect_val("rst_sr",   16'h0); check_obs(16'(sif.soft_reset));
      expect_val("rst_sts",  16'h0); check_obs(16'(sif.timeout_sts));

      // Address steering
      sif.detect_add = 1'b1; sif.data_in = 2'd2;
      step();
      sif.detect_add = 1'b0; sif.write_enb_reg = 1'b1; sif.full = 3'b100; #1;
      expect_val("steer_wen",  16'h4); check_obs(16'(sif.write_enb));
      expect_val("steer_full", 16'h1); check_obs(16'(sif.fifo_full));
      sif.detect_add = 1'b1; sif.data_in = 2'd1; #1;
      expect_val("same_cyc_wen", 16'h4); check_obs(16'(sif.write_enb));
      step();
      sif.detect_add = 1'b0; #1;
      expect_val("new_addr_wen",  16'h2); check_obs(16'(sif.write_enb));
      expect_val("new_addr_full", 16'h0); check_obs(16'(sif.fifo_full));

      // Invalid address
      sif.detect_add = 1'b1; sif.data_in = 2'd3;
      step();
      sif.detect_add = 1'b0; sif.full = 3'b111; #1;
      expect_val("bad_aerr", 16'h1); check_obs(16'(sif.addr_err));
      expect_val("bad_wen",  16'h0); check_obs(16'(sif.write_enb));
      expect_val("bad_full", 16'h0); check_obs(16'(sif.fifo_full));
      sif.detect_add = 1'b1; sif.data_in = 2'd0;
      step();
      sif.detect_add = 1'b0; #1;
      expect_val("fix_aerr", 16'h0); check_obs(16'(sif.addr_err));
      expect_val("fix_wen",  16'h1); check_obs(16'(sif.write_enb));
      sif.write_enb_reg = 1'b0; sif.full = 3'b000;

      // Timeout on channel 0
      sif.empty = 3'b110;
      edges_to_pulse(3'b001, n);
      expect_val("to_first_edges", 16'd30); check_obs(16'(n));
      expect_val("to_sts", 16'h1); check_obs(16'(sif.timeout_sts));
      step();
      expect_val("to_pulse_width", 16'h0); check_obs(16'(sif.soft_reset));
      edges_to_pulse(3'b001, n);
      expect_val("to_second_edges", 16'd29); check_obs(16'(n));

      // Cancel on the terminal cycle
      sif.empty = 3'b111;
      step();
      sif.empty = 3'b110;
      for (int i = 0; i < 29; i++) step();
      expect_val("cancel_pre", 16'h0); check_obs(16'(sif.soft_reset));
      sif.read_enb = 3'b001;
      step();
      sif.read_enb = 3'b000;
      expect_val("cancel_sr", 16'h0); check_obs(16'(sif.soft_reset));
      edges_to_pulse(3'b001, n);
      expect_val("cancel_restart", 16'd30); check_obs(16'(n));

      // Concurrent channels and sticky status
      sif.empty = 3'b111; sif.timeout_clr = 1'b1;
      step();
      sif.timeout_clr = 1'b0;
      expect_val("clr_sts", 16'h0); check_obs(16'(sif.timeout_sts));
      sif.empty = 3'b000;
      for (int i = 0; i < 29; i++) step();
      expect_val("conc_pre", 16'h0); check_obs(16'(sif.soft_reset));
      sif.timeout_clr = 1'b1;
      step();
      expect_val("conc_sr",  16'h7); check_obs(16'(sif.soft_reset));
      expect_val("conc_sts", 16'h7); check_obs(16'(sif.timeout_sts));
      sif.timeout_clr = 1'b0; sif.empty = 3'b111;
      step();
      expect_val("sts_hold", 16'h7); check_obs(16'(sif.timeout_sts));
      sif.timeout_clr = 1'b1;
      step();
      sif.timeout_clr = 1'b0;
      expect_val("sts_clr", 16'h0); check_obs(16'(sif.timeout_sts));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
